// File: rtl/mips_decode_stage.sv
// Decode stage: decodes MIPS add/sub/and/or/xor/nor and addi/andi/ori/xori over valid/ready,
// then queues the decoded bundles in an output FIFO. Also keeps an exception counter and a halt FSM.
module mips_decode_stage #(
  parameter int FIFO_DEPTH     = 2,
  parameter int IMM_WIDTH      = 32,
  parameter int EXC_CNT_WIDTH  = 8,
  parameter int HALT_ON_EXCEPT = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic                     exc_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_alu_op,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_wr_reg,
  output logic [IMM_WIDTH-1:0]     out_imm,
  output logic                     out_alu_src2,
  output logic                     out_writeenable,
  output logic                     out_except,
  output logic [EXC_CNT_WIDTH-1:0] exc_count,
  output logic                     halted
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0]           alu_op;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           wr_reg;
    logic [IMM_WIDTH-1:0] imm;
    logic                 alu_src2;
    logic                 we;
    logic                 except;
  } bundle_t;

  typedef enum logic {RUN, HALT} state_t;

  state_t               state_q, state_d;
  bundle_t              dec;
  bundle_t              mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic                 full, push, pop;
  logic [5:0]           opcode, funct;
  logic [IMM_WIDTH-1:0] sext, zext;

  assign opcode = in_inst[31:26];
  assign funct  = in_inst[5:0];
  assign sext   = IMM_WIDTH'($signed(in_inst[15:0]));
  assign zext   = IMM_WIDTH'(in_inst[15:0]);

  always_comb begin
    dec          = '0;
    dec.rs       = in_inst[25:21];
    dec.rt       = in_inst[20:16];
    dec.imm      = sext;
    dec.except   = 1'b1;
    if (opcode == 6'h00) begin
      dec.wr_reg = in_inst[15:11];
      dec.we     = 1'b1;
      dec.except = 1'b0;
      unique case (funct)
        6'h20:   dec.alu_op = 3'b010;
        6'h22:   dec.alu_op = 3'b011;
        6'h24:   dec.alu_op = 3'b100;
        6'h25:   dec.alu_op = 3'b101;
        6'h26:   dec.alu_op = 3'b111;
        6'h27:   dec.alu_op = 3'b110;
        default: dec.except = 1'b1;
      endcase
    end else begin
      dec.wr_reg   = in_inst[20:16];
      dec.alu_src2 = 1'b1;
      dec.we       = 1'b1;
      dec.except   = 1'b0;
      unique case (opcode)
        6'h08:   dec.alu_op = 3'b010;
        6'h0C: begin dec.alu_op = 3'b100; dec.imm = zext; end
        6'h0D: begin dec.alu_op = 3'b101; dec.imm = zext; end
        6'h0E: begin dec.alu_op = 3'b111; dec.imm = zext; end
        default: dec.except = 1'b1;
      endcase
    end
    // Excepting bundles carry only register fields and the sign-extended immediate.
    if (dec.except) begin
      dec.alu_op   = 3'b000;
      dec.wr_reg   = 5'd0;
      dec.alu_src2 = 1'b0;
      dec.we       = 1'b0;
      dec.imm      = sext;
    end
  end

  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign in_ready  = !full && (state_q == RUN);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (HALT_ON_EXCEPT != 0 && push && dec.except) state_d = HALT;
      HALT: if (exc_clear) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      exc_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push && dec.except && exc_count != '1) exc_count <= exc_count + 1'b1;
    end
  end

  assign out_alu_op      = mem[rd_ptr].alu_op;
  assign out_rs          = mem[rd_ptr].rs;
  assign out_rt          = mem[rd_ptr].rt;
  assign out_wr_reg      = mem[rd_ptr].wr_reg;
  assign out_imm         = mem[rd_ptr].imm;
  assign out_alu_src2    = mem[rd_ptr].alu_src2;
  assign out_writeenable = mem[rd_ptr].we;
  assign out_except      = mem[rd_ptr].except;
endmodule
